// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: constants and types shared by the pipeline control slice.
//   - FSM state encoding for pipe_ctrl
//   - per-stage stall masks (bit 0 = PC ... bit 5 = WB)
//   - ERET exception code, Stop/NoStop, WriteEnable/WriteDisable, ZeroWord
//   - stall_mask(): fixed-priority stall request resolution
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } pipe_state_e;

    localparam logic [5:0]  STALL_NONE = 6'b000000;
    localparam logic [5:0]  STALL_ID   = 6'b000111;
    localparam logic [5:0]  STALL_EX   = 6'b001111;
    localparam logic [5:0]  STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_ERET   = 32'h0000000e;
    localparam logic [31:0] ZeroWord   = 32'h00000000;

    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    // The deepest requesting stage wins: it must freeze everything upstream of it.
    function automatic logic [5:0] stall_mask(input logic req_id,
                                              input logic req_ex,
                                              input logic req_mem);
        logic [5:0] m;
        m = STALL_NONE;
        if (req_mem)     m = STALL_MEM;
        else if (req_ex) m = STALL_EX;
        else if (req_id) m = STALL_ID;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat.sv
// pipe_sat_counter: W-bit up-counter that sticks at all-ones.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-high reset (to zero)
//   inc_i  in   count enable
//   clr_i  in   clear to zero (dominates inc_i)
//   cnt_o  out  current count
module pipe_sat_counter
    import pipe_ctrl_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc_i,
    input  logic         clr_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if ((inc_i == WriteEnable) && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall / flush controller.
// An exception seen in RUN flushes the pipe for one cycle and redirects the PC
// (EPC for ERET, EXC_VECTOR otherwise); the following REDIRECT cycle ignores the
// exception input so a still-asserted excepttype_i cannot re-trigger.
// Optional watchdog: define PIPE_STALL_WDT_EN to raise wdt_irq_o after WDT_LIMIT
// consecutive stalled cycles; without it wdt_irq_o is tied low.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   stallreq_id/ex/mem               per-stage stall requests
//   excepttype_i, cp0_epc_i          MEM-stage exception code, current EPC
//   stall[5:0], flush, new_pc        pipeline control (combinational)
//   stall_cnt_o, flush_cnt_o         saturating event counters
//   wdt_irq_o, wdt_clr_i             watchdog alarm and its clear
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h00000020,
    parameter int          WDT_LIMIT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o,
    output logic        wdt_irq_o,
    input  logic        wdt_clr_i
);

    pipe_state_e state_q;
    pipe_state_e state_d;
    logic        exc_take;
    logic        stall_any;
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    assign exc_take = (state_q == ST_RUN) && (excepttype_i != ZeroWord);

    always_comb begin
        state_d = ST_RUN;
        case (state_q)
            ST_RUN:      state_d = exc_take ? ST_REDIRECT : ST_RUN;
            ST_REDIRECT: state_d = ST_RUN;
            default:     state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_RUN;
        else     state_q <= state_d;
    end

    // Outputs are forced quiet while rst is high so nothing leaks from a
    // half-finished redirect or stall.
    always_comb begin
        flush  = WriteDisable;
        stall  = STALL_NONE;
        new_pc = ZeroWord;
        if (!rst) begin
            if (exc_take) begin
                flush  = WriteEnable;
                new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end else begin
                stall = stall_mask(stallreq_id, stallreq_ex, stallreq_mem);
            end
        end
    end

    assign stall_any = (stall != STALL_NONE) ? Stop : NoStop;

    pipe_sat_counter #(.W(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_any),
        .clr_i (1'b0),
        .cnt_o (stall_cnt_q)
    );

    pipe_sat_counter #(.W(16)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (flush),
        .clr_i (1'b0),
        .cnt_o (flush_cnt_q)
    );

    assign stall_cnt_o = rst ? ZeroWord : stall_cnt_q;
    assign flush_cnt_o = rst ? 16'h0000 : flush_cnt_q;

`ifdef PIPE_STALL_WDT_EN
    // Counter holds the length of the current unbroken stall run. The alarm is
    // set on the same edge the run length reaches WDT_LIMIT.
    localparam logic [15:0] WDT_SET_AT = 16'(WDT_LIMIT - 1);

    logic [15:0] wdt_cnt_q;
    logic        wdt_irq_q;
    logic        wdt_irq_d;

    pipe_sat_counter #(.W(16)) u_wdt_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall_any),
        .clr_i (wdt_clr_i || !stall_any),
        .cnt_o (wdt_cnt_q)
    );

    always_comb begin
        wdt_irq_d = wdt_irq_q;
        if (wdt_clr_i)
            wdt_irq_d = 1'b0;
        else if (stall_any && (wdt_cnt_q >= WDT_SET_AT))
            wdt_irq_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) wdt_irq_q <= 1'b0;
        else     wdt_irq_q <= wdt_irq_d;
    end

    assign wdt_irq_o = rst ? 1'b0 : wdt_irq_q;
`else
    logic        unused_wdt_clr;
    logic [15:0] unused_wdt_limit;

    assign unused_wdt_clr   = wdt_clr_i;
    assign unused_wdt_limit = 16'(WDT_LIMIT);
    assign wdt_irq_o        = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    localparam int LIMIT = 4;
`ifdef PIPE_STALL_WDT_EN
    localparam bit WDT_ON = 1'b1;
`else
    localparam bit WDT_ON = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic [31:0] excepttype_i, cp0_epc_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;
    logic        wdt_irq_o;
    logic        wdt_clr_i;

    pipe_ctrl #(.EXC_VECTOR(32'h00000020), .WDT_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o),
        .wdt_irq_o    (wdt_irq_o),
        .wdt_clr_i    (wdt_clr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: "the previous cycle was a flush", event tallies, stall run length.
    bit          m_after_flush;
    longint      m_scnt;
    int          m_fcnt;
    int          m_run;
    bit          m_irq;

    typedef struct {
        logic        id, ex, mem;
        logic [31:0] exc, epc;
        logic [5:0]  e_stall;
        logic        e_flush;
        logic [31:0] e_pc;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic expect_now(output logic f, output logic [5:0] s, output logic [31:0] pc);
        f  = 1'b0;
        s  = 6'd0;
        pc = 32'd0;
        if (!rst) begin
            if (!m_after_flush && excepttype_i != 0) begin
                f  = 1'b1;
                pc = (excepttype_i == 32'he) ? cp0_epc_i : 32'h20;
            end else if (stallreq_mem) s = 6'b011111;
            else if (stallreq_ex)      s = 6'b001111;
            else if (stallreq_id)      s = 6'b000111;
        end
    endtask

    task automatic at_neg(input string nm);
        logic f;
        logic [5:0] s;
        logic [31:0] pc;
        @(negedge clk);
        expect_now(f, s, pc);
        chk({nm, ".stall"}, 32'(stall), 32'(s));
        chk({nm, ".flush"}, 32'(flush), 32'(f));
        chk({nm, ".new_pc"}, new_pc, pc);
        chk({nm, ".stall_cnt"}, stall_cnt_o, rst ? 32'd0 : 32'(m_scnt));
        chk({nm, ".flush_cnt"}, 32'(flush_cnt_o), rst ? 32'd0 : 32'(m_fcnt));
        chk({nm, ".wdt_irq"}, 32'(wdt_irq_o), (rst || !WDT_ON) ? 32'd0 : 32'(m_irq));
    endtask

    task automatic adv();
        logic f;
        logic [5:0] s;
        logic [31:0] pc;
        @(posedge clk);
        expect_now(f, s, pc);
        if (rst) begin
            m_after_flush = 0; m_scnt = 0; m_fcnt = 0; m_run = 0; m_irq = 0;
        end else begin
            if (s != 0 && m_scnt < 64'hFFFFFFFF) m_scnt++;
            if (f && m_fcnt < 65535) m_fcnt++;
            m_after_flush = f;
            if (wdt_clr_i) begin
                m_run = 0; m_irq = 0;
            end else if (s != 0) begin
                m_run++;
                if (m_run >= LIMIT) m_irq = 1;
            end else begin
                m_run = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        stallreq_id = 0; stallreq_ex = 0; stallreq_mem = 0;
        excepttype_i = 0; cp0_epc_i = 0; wdt_clr_i = 0;
    endtask

    task automatic reset_dut();
        rst = 1;
        idle_inputs();
        at_neg("reset");
        adv();
        adv();
        rst = 0;
    endtask

    initial begin
        m_after_flush = 0; m_scnt = 0; m_fcnt = 0; m_run = 0; m_irq = 0;
        rst = 1;
        idle_inputs();

        //             id ex mem exc     epc            stall      flush pc
        tbl[0]  = '{0, 1, 0, 32'h0, 32'h0,         6'b001111, 0, 32'h0};
        tbl[1]  = '{1, 0, 1, 32'h0, 32'h0,         6'b011111, 0, 32'h0};
        tbl[2]  = '{1, 0, 0, 32'h0, 32'h0,         6'b000111, 0, 32'h0};
        tbl[3]  = '{0, 0, 0, 32'h0, 32'h0,         6'b000000, 0, 32'h0};
        tbl[4]  = '{0, 0, 1, 32'h8, 32'h1234,      6'b000000, 1, 32'h20};
        tbl[5]  = '{0, 0, 1, 32'h8, 32'h1234,      6'b011111, 0, 32'h0};
        tbl[6]  = '{0, 0, 0, 32'he, 32'h1234,      6'b000000, 1, 32'h1234};
        tbl[7]  = '{0, 1, 0, 32'he, 32'h1234,      6'b001111, 0, 32'h0};
        tbl[8]  = '{1, 0, 0, 32'h4, 32'hdead0000,  6'b000000, 1, 32'h20};
        tbl[9]  = '{0, 0, 0, 32'h0, 32'h0,         6'b000000, 0, 32'h0};
        tbl[10] = '{1, 1, 0, 32'h0, 32'h0,         6'b001111, 0, 32'h0};

        reset_dut();
        for (int i = 0; i < 11; i++) begin
            stallreq_id  = tbl[i].id;
            stallreq_ex  = tbl[i].ex;
            stallreq_mem = tbl[i].mem;
            excepttype_i = tbl[i].exc;
            cp0_epc_i    = tbl[i].epc;
            at_neg($sformatf("vec%0d", i));
            chk($sformatf("tbl%0d.stall", i), 32'(stall), 32'(tbl[i].e_stall));
            chk($sformatf("tbl%0d.flush", i), 32'(flush), 32'(tbl[i].e_flush));
            chk($sformatf("tbl%0d.new_pc", i), new_pc, tbl[i].e_pc);
            adv();
        end
        idle_inputs();
        at_neg("after_tbl");
        chk("tbl.flush_cnt", 32'(flush_cnt_o), 32'd3);

        // EX stall held three cycles from a fresh reset.
        reset_dut();
        chk("ex3.cnt_start", stall_cnt_o, 32'd0);
        stallreq_ex = 1;
        for (int k = 0; k < 3; k++) begin
            at_neg("ex3");
            chk("ex3.stall", 32'(stall), 32'h0f);
            adv();
        end
        stallreq_ex = 0;
        at_neg("ex3.end");
        chk("ex3.cnt_end", stall_cnt_o, 32'd3);
        adv();

        // Watchdog: six stalled cycles, alarm from the fourth edge, then cleared.
        reset_dut();
        stallreq_ex = 1;
        for (int k = 1; k <= 6; k++) begin
            at_neg("wdt");
            adv();
            chk($sformatf("wdt.irq_edge%0d", k), 32'(wdt_irq_o),
                (WDT_ON && k >= LIMIT) ? 32'd1 : 32'd0);
        end
        stallreq_ex = 0;
        wdt_clr_i = 1;
        at_neg("wdt.clr");
        adv();
        wdt_clr_i = 0;
        chk("wdt.irq_cleared", 32'(wdt_irq_o), 32'd0);

        // Reset landing in the REDIRECT cycle with nonzero counters.
        reset_dut();
        stallreq_mem = 1;
        at_neg("rr.s1"); adv();
        at_neg("rr.s2"); adv();
        excepttype_i = 32'h8;
        at_neg("rr.exc");
        chk("rr.flush_in", 32'(flush), 32'd1);
        adv();
        rst = 1;
        at_neg("rr.rst");
        chk("rr.rst_flush", 32'(flush), 32'd0);
        chk("rr.rst_stall", 32'(stall), 32'd0);
        chk("rr.rst_newpc", new_pc, 32'd0);
        adv();
        chk("rr.rst_scnt", stall_cnt_o, 32'd0);
        chk("rr.rst_fcnt", 32'(flush_cnt_o), 32'd0);
        rst = 0;
        stallreq_mem = 0;
        at_neg("rr.post");
        chk("rr.post_flush", 32'(flush), 32'd1);
        chk("rr.post_pc", new_pc, 32'h20);
        adv();
        idle_inputs();

        // Randomized traffic against the reference model.
        reset_dut();
        for (int n = 0; n < 600; n++) begin
            rst          = ($urandom % 50) == 0;
            stallreq_id  = $urandom % 2;
            stallreq_ex  = ($urandom % 3) != 0;
            stallreq_mem = ($urandom % 4) == 0;
            if (($urandom % 7) == 0)
                excepttype_i = (($urandom % 3) == 0) ? 32'he : 32'($urandom_range(1, 31));
            else
                excepttype_i = 32'h0;
            cp0_epc_i    = $urandom;
            wdt_clr_i    = ($urandom % 20) == 0;
            at_neg("rnd");
            adv();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameters: EXC_VECTOR, 32'h00000020, handler entry PC; WDT_LIMIT, 255, watchdog stall-cycle limit (1..65535).
REQ-002 SHALL have ports (clock and reset first):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- stallreq_id  in  1  ID stage stall request.
- stallreq_ex  in  1  EX stage stall request (multi-cycle MADD/DIV).
- stallreq_mem  in  1  MEM stage stall request (bus wait).
- excepttype_i  in  32  MEM-stage exception type; 0 means none.
- cp0_epc_i  in  32  current EPC.
- stall  out  6  per-stage stall: [0] PC, [1] IF, [2] ID, [3] EX, [4] MEM, [5] WB.
- flush  out  1  flush all pipeline registers.
- new_pc  out  32  redirect target, valid while flush=1.
- stall_cnt_o  out  32  saturating count of cycles with stall!=0.
- flush_cnt_o  out  16  saturating count of flush pulses.
- wdt_irq_o  out  1  watchdog alarm (PIPE_STALL_WDT_EN only, else tied 0).
- wdt_clr_i  in  1  clears wdt_irq_o.

Function
REQ-003 SHALL implement FSM states RUN and REDIRECT; reset state RUN.
REQ-004 In RUN with excepttype_i!=0: flush=1, stall=6'b000000 the same cycle (combinational); next state REDIRECT.
REQ-005 new_pc SHALL be cp0_epc_i when excepttype_i==32'h0000000e (ERET), else EXC_VECTOR; 32'h0 when flush=0.
REQ-006 In REDIRECT: flush=0, excepttype_i ignored, stall computed from requests; unconditional return to RUN next cycle.
REQ-007 Stall priority when no flush: stallreq_mem -> 6'b011111; else stallreq_ex -> 6'b001111; else stallreq_id -> 6'b000111; else 6'b000000.
REQ-008 Exception SHALL override all stall requests in the same cycle.
REQ-009 stall_cnt_o SHALL increment by 1 each cycle stall!=0, saturating at 32'hFFFFFFFF.
REQ-010 flush_cnt_o SHALL increment by 1 each cycle flush=1, saturating at 16'hFFFF.
REQ-011 stall and flush SHALL be combinational from FSM state and inputs; counters and FSM registered.

Reset
REQ-012 While rst=1: state RUN, flush=0, stall=6'b000000, new_pc=0, stall_cnt_o=0, flush_cnt_o=0, wdt_irq_o=0, watchdog counter=0; all inputs ignored.
REQ-013 rst asserted mid-REDIRECT or mid-stall SHALL abort immediately; first post-reset cycle is RUN.

Configuration
REQ-014 Macro PIPE_STALL_WDT_EN SHALL compile in a 16-bit watchdog counter.
REQ-015 With macro: counter increments each cycle stall!=0, clears to 0 when stall==0 or flush=1; on reaching WDT_LIMIT, wdt_irq_o sets next edge and holds; wdt_clr_i=1 clears wdt_irq_o and counter; simultaneous set and clear -> clear wins.
REQ-016 Without macro: no watchdog registers, wdt_irq_o constant 0, wdt_clr_i unused.

Structure
REQ-017 Shared defines package SHALL hold stall masks, ERET code 32'h0000000e, Stop/NoStop, WriteEnable/Disable, ZeroWord.
REQ-018 Sub-module pipe_sat_counter (parameterised width, inc, clr, saturate) SHALL be instantiated for stall, flush and watchdog counters.
REQ-019 Counter logic SHALL be separate from the FSM.

Verification
REQ-020 stallreq_ex=1 for 3 cycles, others 0 -> stall=6'b001111 for 3 cycles, stall_cnt_o 0->3.
REQ-021 stallreq_id=1, stallreq_mem=1 together -> stall=6'b011111.
REQ-022 excepttype_i=32'h00000008 with stallreq_mem=1 -> flush=1, stall=0, new_pc=32'h20; next cycle excepttype_i=32'h8 still -> flush=0; flush_cnt_o=1.
REQ-023 excepttype_i=32'h0000000e, cp0_epc_i=32'h00001234 -> new_pc=32'h00001234, flush=1.
REQ-024 With PIPE_STALL_WDT_EN, WDT_LIMIT=4, stallreq_ex held 6 cycles -> wdt_irq_o=1 after 4th stalled edge; wdt_clr_i pulse -> 0.
REQ-025 rst=1 asserted during REDIRECT with counters nonzero -> all outputs 0, state RUN next cycle.
